// File: rtl/ysyx_22051013_lsu_gen.sv
// Load/store unit between EX and WB: one memory op in flight, a single request/response
// transaction on a generic memory port, and valid/ready handshakes towards EX and WB.
module ysyx_22051013_lsu_gen #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  output logic                ls_ready,
  input  logic [DATA_W-1:0]   alu_res,
  input  logic [DATA_W-1:0]   store_data,
  input  logic [3:0]          ls_ctl,
  output logic                ls_valid,
  input  logic                wb_ready,
  output logic [DATA_W-1:0]   ls_data_o,
  output logic [1:0]          ls_exc,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam bit WIDE   = (DATA_W == 64);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Doubleword accesses only exist on a 64-bit datapath.
  function automatic logic ctl_legal(input logic [3:0] ctl);
    case (ctl)
      4'b0000, 4'b1001, 4'b1010, 4'b1011, 4'b1101, 4'b1110,
      4'b0001, 4'b0010, 4'b0100: ctl_legal = 1'b1;
      4'b1100, 4'b1111, 4'b0101: ctl_legal = WIDE;
      default:                   ctl_legal = 1'b0;
    endcase
  endfunction

  // log2 of the access size in bytes
  function automatic logic [1:0] ctl_size(input logic [3:0] ctl);
    case (ctl)
      4'b1010, 4'b1110, 4'b0010: ctl_size = 2'd1;
      4'b1011, 4'b1111, 4'b0100: ctl_size = 2'd2;
      4'b1100, 4'b0101:          ctl_size = 2'd3;
      default:                   ctl_size = 2'd0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo);
    case (size)
      2'd1:    misaligned = lo[0];
      2'd2:    misaligned = |lo[1:0];
      2'd3:    misaligned = |lo;
      default: misaligned = 1'b0;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [3:0]          ctl_q, ctl_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   sdata_q, sdata_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          exc_q, exc_d;

  logic                accept;
  logic                in_req;
  logic [1:0]          size_q;
  logic                store_q;
  logic                zext_q;
  logic [OFF_W-1:0]    off_q;
  logic [DATA_W-1:0]   rshift;
  logic [DATA_W-1:0]   load_val;
  logic [DATA_W-1:0]   wdata_lane;
  logic [STRB_W-1:0]   strb_base;

  assign size_q  = ctl_size(ctl_q);
  assign store_q = ~ctl_q[3];
  assign zext_q  = (ctl_q[3:2] == 2'b11);
  assign off_q   = addr_q[OFF_W-1:0];
  assign in_req  = (state_q == REQ);

  assign ls_ready = (state_q == IDLE) | ((state_q == DONE) & wb_ready);
  assign accept   = ex_valid & ls_ready;

  // Move the addressed lane down to bit 0, then extend according to size/signedness.
  assign rshift = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_val = '0;
    case (size_q)
      2'd0:    load_val = zext_q ? DATA_W'(rshift[7:0])  : DATA_W'($signed(rshift[7:0]));
      2'd1:    load_val = zext_q ? DATA_W'(rshift[15:0]) : DATA_W'($signed(rshift[15:0]));
      2'd2:    load_val = zext_q ? DATA_W'(rshift[31:0]) : DATA_W'($signed(rshift[31:0]));
      default: load_val = rshift;
    endcase
  end

  // Store data is replicated across all lanes so the strobes alone select the bytes.
  always_comb begin
    wdata_lane = sdata_q;
    strb_base  = '1;
    case (size_q)
      2'd0: begin
        wdata_lane = {STRB_W{sdata_q[7:0]}};
        strb_base  = STRB_W'(1);
      end
      2'd1: begin
        wdata_lane = {(DATA_W/16){sdata_q[15:0]}};
        strb_base  = STRB_W'(3);
      end
      2'd2: begin
        wdata_lane = {(DATA_W/32){sdata_q[31:0]}};
        strb_base  = STRB_W'(15);
      end
      default: begin
        wdata_lane = sdata_q;
        strb_base  = '1;
      end
    endcase
  end

  assign mem_req_valid = in_req;
  assign mem_we        = in_req & store_q;
  assign mem_addr      = in_req ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_wdata     = (in_req & store_q) ? wdata_lane : '0;
  assign mem_wstrb     = (in_req & store_q) ? (strb_base << off_q) : '0;

  assign ls_valid  = (state_q == DONE);
  assign ls_data_o = data_q;
  assign ls_exc    = exc_q;

  always_comb begin
    state_d = state_q;
    ctl_d   = ctl_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    data_d  = data_q;
    exc_d   = exc_q;

    case (state_q)
      REQ: begin
        if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = DONE;
          if (mem_err) begin
            data_d = '0;
            exc_d  = 2'b10;
          end else begin
            data_d = store_q ? '0 : load_val;
            exc_d  = 2'b00;
          end
        end
      end
      DONE: begin
        if (wb_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
      end
    endcase

    // Acceptance overrides the above so DONE can hand over to the next op without a bubble.
    if (accept) begin
      ctl_d   = ls_ctl;
      addr_d  = alu_res[ADDR_W-1:0];
      sdata_d = store_data;
      data_d  = '0;
      exc_d   = 2'b00;
      if (!ctl_legal(ls_ctl)) begin
        state_d = DONE;
        exc_d   = 2'b11;
      end else if (ls_ctl == 4'b0000) begin
        state_d = DONE;
        data_d  = alu_res;
      end else if (misaligned(ctl_size(ls_ctl), alu_res[2:0])) begin
        state_d = DONE;
        exc_d   = 2'b01;
      end else begin
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ctl_q   <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      data_q  <= '0;
      exc_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_lsu_gen.sv
// Directed bench for the LSU: a 64-bit instance carries most scenarios, a 32-bit
// instance covers the doubleword-illegal encodings.
module tb_ysyx_22051013_lsu_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        ex_valid = 1'b0, ls_ready, ls_valid, wb_ready = 1'b1;
  logic [63:0] alu_res = '0, store_data = '0, ls_data_o, mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  ls_ctl = '0;
  logic [1:0]  ls_exc;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_we, mem_rvalid = 1'b0, mem_err = 1'b0;
  logic [7:0]  mem_wstrb;

  logic        n_ex_valid = 1'b0, n_ls_ready, n_ls_valid, n_wb_ready = 1'b1;
  logic [31:0] n_alu_res = '0, n_store_data = '0, n_ls_data_o, n_mem_addr, n_mem_wdata, n_mem_rdata = '0;
  logic [3:0]  n_ls_ctl = '0;
  logic [1:0]  n_ls_exc;
  logic        n_mem_req_valid, n_mem_req_ready = 1'b0, n_mem_we, n_mem_rvalid = 1'b0, n_mem_err = 1'b0;
  logic [3:0]  n_mem_wstrb;

  int checks = 0;
  int errors = 0;

  ysyx_22051013_lsu_gen #(.DATA_W(64), .ADDR_W(64)) u64 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ls_ready(ls_ready), .alu_res(alu_res),
    .store_data(store_data), .ls_ctl(ls_ctl), .ls_valid(ls_valid), .wb_ready(wb_ready),
    .ls_data_o(ls_data_o), .ls_exc(ls_exc), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  ysyx_22051013_lsu_gen #(.DATA_W(32), .ADDR_W(32)) u32 (
    .clk(clk), .rst(rst), .ex_valid(n_ex_valid), .ls_ready(n_ls_ready), .alu_res(n_alu_res),
    .store_data(n_store_data), .ls_ctl(n_ls_ctl), .ls_valid(n_ls_valid), .wb_ready(n_wb_ready),
    .ls_data_o(n_ls_data_o), .ls_exc(n_ls_exc), .mem_req_valid(n_mem_req_valid),
    .mem_req_ready(n_mem_req_ready), .mem_we(n_mem_we), .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata),
    .mem_wstrb(n_mem_wstrb), .mem_rvalid(n_mem_rvalid), .mem_rdata(n_mem_rdata), .mem_err(n_mem_err)
  );

  // Drives one op into the 64-bit instance and plays the memory side; reports what it saw.
  task automatic run_op(input logic [3:0] ctl, input logic [63:0] addr, input logic [63:0] sdata,
                        input logic [63:0] rdata, input logic err, input int req_stall,
                        input int rsp_stall, input logic noise,
                        output logic [63:0] data, output logic [1:0] exc, output int lat,
                        output int req_cycles, output logic stable, output logic [63:0] s_addr,
                        output logic [63:0] s_wdata, output logic [7:0] s_wstrb, output logic s_we);
    int phase;
    int rq;
    int rs;
    phase = 0; rq = req_stall; rs = rsp_stall;
    lat = -1; req_cycles = 0; stable = 1'b1; data = '0; exc = '0;
    s_addr = '0; s_wdata = '0; s_wstrb = '0; s_we = 1'b0;
    @(posedge clk); #2;
    ex_valid = 1'b1; ls_ctl = ctl; alu_res = addr; store_data = sdata;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; wb_ready = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #2;
      ex_valid = 1'b0; ls_ctl = '0; alu_res = '0; store_data = '0;
      mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
      if (ls_valid) begin
        data = ls_data_o; exc = ls_exc; lat = c;
        break;
      end
      if (phase == 0 && mem_req_valid) begin
        if (req_cycles == 0) begin
          s_addr = mem_addr; s_wdata = mem_wdata; s_wstrb = mem_wstrb; s_we = mem_we;
        end else if (mem_addr !== s_addr || mem_wdata !== s_wdata || mem_wstrb !== s_wstrb || mem_we !== s_we) begin
          stable = 1'b0;
        end
        req_cycles++;
        if (rq > 0) begin
          rq--;
          mem_rvalid = noise; mem_err = noise; mem_rdata = {64{noise}};
        end else begin
          mem_req_ready = 1'b1; phase = 1;
        end
      end else if (phase == 1) begin
        if (rs > 0) rs--;
        else begin
          mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err; phase = 2;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (ls_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ls_ready: got %b expected 1", ls_ready); end
    checks++; if (ls_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ls_valid: got %b expected 0", ls_valid); end
    checks++; if (mem_req_valid !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 8'h0) begin
      errors++; $display("[TB] FAIL reset_mem: got req %b we %b wstrb %h expected 0 0 00", mem_req_valid, mem_we, mem_wstrb); end
    checks++; if (ls_data_o !== 64'h0 || ls_exc !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_result: got %h/%b expected 0/00", ls_data_o, ls_exc); end
    checks++; if (n_ls_ready !== 1'b1 || n_ls_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_n32: got ready %b valid %b expected 1 0", n_ls_ready, n_ls_valid); end
    rst = 1'b1;
  endtask

  task automatic test_nonmem();
    logic [63:0] d, sa, sw; logic [1:0] e; int lat, rc; logic st, swe; logic [7:0] ss;
    run_op(4'b0000, 64'h1234_5678_9ABC_DEF1, 64'h0, 64'h0, 1'b0, 0, 0, 1'b0, d, e, lat, rc, st, sa, sw, ss, swe);
    checks++; if (d !== 64'h1234_5678_9ABC_DEF1) begin errors++; $display("[TB] FAIL nonmem_data: got %h expected 123456789abcdef1", d); end
    checks++; if (e !== 2'b00) begin errors++; $display("[TB] FAIL nonmem_exc: got %b expected 00", e); end
    checks++; if (lat != 1 || rc != 0) begin errors++; $display("[TB] FAIL nonmem_timing: got lat %0d req %0d expected 1 0", lat, rc); end
  endtask

  task automatic test_load();
    logic [3:0] ctl_t [7];
    logic [63:0] a_t [7], rd_t [7], exp_t [7];
    logic [63:0] d, sa, sw; logic [1:0] e; int lat, rc; logic st, swe; logic [7:0] ss;
    ctl_t = '{4'b1001, 4'b1101, 4'b1010, 4'b1110, 4'b1011, 4'b1111, 4'b1100};
    a_t   = '{64'h1003, 64'h1003, 64'h2006, 64'h2006, 64'h2004, 64'h2004, 64'h2008};
    rd_t  = '{64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 64'h8001_0000_0000_0000,
              64'h8001_0000_0000_0000, 64'h8765_4321_0000_0000, 64'h8765_4321_0000_0000,
              64'h0123_4567_89AB_CDEF};
    exp_t = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80, 64'hFFFF_FFFF_FFFF_8001, 64'h8001,
              64'hFFFF_FFFF_8765_4321, 64'h8765_4321, 64'h0123_4567_89AB_CDEF};
    for (int i = 0; i < 7; i++) begin
      run_op(ctl_t[i], a_t[i], 64'hFFFF_FFFF_FFFF_FFFF, rd_t[i], 1'b0, 0, 0, 1'b0, d, e, lat, rc, st, sa, sw, ss, swe);
      checks++; if (d !== exp_t[i] || e !== 2'b00) begin
        errors++; $display("[TB] FAIL load_data[%0d]: got %h/%b expected %h/00", i, d, e, exp_t[i]); end
      checks++; if (lat != 3) begin errors++; $display("[TB] FAIL load_latency[%0d]: got %0d expected 3", i, lat); end
      checks++; if (sa !== {a_t[i][63:3], 3'b000}) begin
        errors++; $display("[TB] FAIL load_addr[%0d]: got %h expected %h", i, sa, {a_t[i][63:3], 3'b000}); end
      checks++; if (ss !== 8'h00 || swe !== 1'b0) begin
        errors++; $display("[TB] FAIL load_rd[%0d]: got wstrb %h we %b expected 00 0", i, ss, swe); end
    end
  endtask

  task automatic test_store();
    logic [3:0] ctl_t [4];
    logic [63:0] a_t [4], sd_t [4], m_t [4];
    logic [7:0] sb_t [4];
    logic [63:0] d, sa, sw; logic [1:0] e; int lat, rc; logic st, swe; logic [7:0] ss;
    ctl_t = '{4'b0010, 4'b0001, 4'b0100, 4'b0101};
    a_t   = '{64'h1006, 64'h1005, 64'h100C, 64'h1010};
    sd_t  = '{64'hFFFF_FFFF_FFFF_ABCD, 64'h0000_0000_0012_345A, 64'h1111_2222_DEAD_BEEF, 64'h0123_4567_89AB_CDEF};
    m_t   = '{64'hFFFF, 64'hFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    sb_t  = '{8'hC0, 8'h20, 8'hF0, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      run_op(ctl_t[i], a_t[i], sd_t[i], 64'hDEAD_DEAD_DEAD_DEAD, 1'b0, 0, 0, 1'b0, d, e, lat, rc, st, sa, sw, ss, swe);
      checks++; if (((sw >> (8 * int'(a_t[i][2:0]))) & m_t[i]) !== (sd_t[i] & m_t[i])) begin
        errors++; $display("[TB] FAIL store_lane[%0d]: got wdata %h expected lane %h", i, sw, sd_t[i] & m_t[i]); end
      checks++; if (ss !== sb_t[i] || swe !== 1'b1) begin
        errors++; $display("[TB] FAIL store_strb[%0d]: got %h we %b expected %h 1", i, ss, swe, sb_t[i]); end
      checks++; if (sa !== {a_t[i][63:3], 3'b000}) begin
        errors++; $display("[TB] FAIL store_addr[%0d]: got %h expected %h", i, sa, {a_t[i][63:3], 3'b000}); end
      checks++; if (d !== 64'h0 || e !== 2'b00 || lat != 3) begin
        errors++; $display("[TB] FAIL store_result[%0d]: got %h/%b lat %0d expected 0/00 lat 3", i, d, e, lat); end
    end
  endtask

  task automatic test_trap();
    logic [3:0] ctl_t [9];
    logic [63:0] a_t [9];
    logic [1:0] x_t [9];
    logic [63:0] d, sa, sw; logic [1:0] e; int lat, rc; logic st, swe; logic [7:0] ss;
    ctl_t = '{4'b1011, 4'b0010, 4'b1100, 4'b0101, 4'b1110, 4'b0011, 4'b0110, 4'b0111, 4'b1000};
    a_t   = '{64'h1002, 64'h1001, 64'h1004, 64'h100A, 64'h1003,
              64'hFFFF_0000_0000_0008, 64'hFFFF_0000_0000_0008, 64'hFFFF_0000_0000_0008, 64'hFFFF_0000_0000_0008};
    x_t   = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
    for (int i = 0; i < 9; i++) begin
      run_op(ctl_t[i], a_t[i], 64'h55, 64'h0, 1'b0, 0, 0, 1'b0, d, e, lat, rc, st, sa, sw, ss, swe);
      checks++; if (e !== x_t[i] || d !== 64'h0) begin
        errors++; $display("[TB] FAIL trap_result[%0d]: got %h/%b expected 0/%b", i, d, e, x_t[i]); end
      checks++; if (lat != 1 || rc != 0) begin
        errors++; $display("[TB] FAIL trap_timing[%0d]: got lat %0d req %0d expected 1 0", i, lat, rc); end
    end
  endtask

  task automatic test_narrow();
    logic [3:0] ctl_t [4];
    logic [31:0] a_t [4];
    logic [1:0] x_t [4];
    ctl_t = '{4'b1100, 4'b1111, 4'b0101, 4'b1011};
    a_t   = '{32'h100, 32'h104, 32'h108, 32'h106};
    x_t   = '{2'b11, 2'b11, 2'b11, 2'b01};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      n_ex_valid = 1'b1; n_ls_ctl = ctl_t[i]; n_alu_res = a_t[i];
      @(posedge clk); #2;
      n_ex_valid = 1'b0;
      checks++; if (n_ls_valid !== 1'b1 || n_ls_exc !== x_t[i] || n_ls_data_o !== 32'h0 || n_mem_req_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL narrow[%0d]: got valid %b exc %b data %h req %b expected 1 %b 0 0",
                           i, n_ls_valid, n_ls_exc, n_ls_data_o, n_mem_req_valid, x_t[i]); end
    end
  endtask

  task automatic test_stall_err();
    logic [63:0] d, sa, sw; logic [1:0] e; int lat, rc; logic st, swe; logic [7:0] ss;
    run_op(4'b1011, 64'h3000, 64'h0, 64'hFFFF_FFFF, 1'b1, 4, 2, 1'b1, d, e, lat, rc, st, sa, sw, ss, swe);
    checks++; if (st !== 1'b1) begin errors++; $display("[TB] FAIL stall_stable: got %b expected 1", st); end
    checks++; if (e !== 2'b10 || d !== 64'h0) begin errors++; $display("[TB] FAIL stall_err: got %h/%b expected 0/10", d, e); end
    checks++; if (lat != 9 || rc != 5) begin errors++; $display("[TB] FAIL stall_timing: got lat %0d req %0d expected 9 5", lat, rc); end
    checks++; if (sa !== 64'h3000) begin errors++; $display("[TB] FAIL stall_addr: got %h expected 3000", sa); end
    run_op(4'b1110, 64'h2006, 64'h0, 64'h8001_0000_0000_0000, 1'b0, 0, 1, 1'b0, d, e, lat, rc, st, sa, sw, ss, swe);
    checks++; if (d !== 64'h8001 || e !== 2'b00 || lat != 4) begin
      errors++; $display("[TB] FAIL rsp_wait: got %h/%b lat %0d expected 8001/00 lat 4", d, e, lat); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #2;
    ex_valid = 1'b1; ls_ctl = 4'b0000; alu_res = 64'hAAAA_0001; wb_ready = 1'b1;
    @(posedge clk); #2;
    wb_ready = 1'b0; alu_res = 64'hBBBB_0002;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #2; end
      #1;
      checks++; if (ls_valid !== 1'b1 || ls_data_o !== 64'hAAAA_0001 || ls_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL b2b_hold[%0d]: got valid %b data %h ready %b expected 1 aaaa0001 0", i, ls_valid, ls_data_o, ls_ready); end
    end
    @(posedge clk); #2;
    wb_ready = 1'b1; #1;
    checks++; if (ls_ready !== 1'b1 || ls_data_o !== 64'hAAAA_0001) begin
      errors++; $display("[TB] FAIL b2b_release: got ready %b data %h expected 1 aaaa0001", ls_ready, ls_data_o); end
    @(posedge clk); #2;
    alu_res = 64'hCCCC_0003;
    checks++; if (ls_valid !== 1'b1 || ls_data_o !== 64'hBBBB_0002) begin
      errors++; $display("[TB] FAIL b2b_next: got valid %b data %h expected 1 bbbb0002", ls_valid, ls_data_o); end
    @(posedge clk); #2;
    ex_valid = 1'b0;
    checks++; if (ls_valid !== 1'b1 || ls_data_o !== 64'hCCCC_0003) begin
      errors++; $display("[TB] FAIL b2b_third: got valid %b data %h expected 1 cccc0003", ls_valid, ls_data_o); end
    @(posedge clk); #2;
    checks++; if (ls_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b expected 0", ls_valid); end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #2;
    ex_valid = 1'b1; ls_ctl = 4'b1011; alu_res = 64'h4000; mem_req_ready = 1'b1; wb_ready = 1'b1;
    @(posedge clk); #2;
    ex_valid = 1'b0; ls_ctl = '0;
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_req: got %b expected 1", mem_req_valid); end
    @(posedge clk); #2;
    mem_req_ready = 1'b0; rst = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h1234_5678; mem_err = 1'b0; #1;
    checks++; if (ls_valid !== 1'b0 || ls_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset: got valid %b ready %b req %b expected 0 1 0", ls_valid, ls_ready, mem_req_valid); end
    @(posedge clk); #2;
    mem_rvalid = 1'b0; mem_rdata = '0;
    checks++; if (ls_valid !== 1'b0 || ls_data_o !== 64'h0 || ls_exc !== 2'b00) begin
      errors++; $display("[TB] FAIL mid_late_rvalid: got valid %b data %h exc %b expected 0 0 00", ls_valid, ls_data_o, ls_exc); end
    @(posedge clk); #2;
    checks++; if (ls_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_idle: got %b expected 0", ls_valid); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_nonmem();
    test_load();
    test_store();
    test_trap();
    test_narrow();
    test_stall_err();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22051013_lsu_gen.md
# ysyx_22051013_lsu_gen

Parametrised load/store unit for the pipelined core, sitting between the EX stage and the WB stage. It accepts one memory operation at a time from EX and issues a single request/response transaction on a generic memory port. It returns sign- or zero-extended load data (or passes ALU results through for non-memory ops) to WB with valid/ready handshakes on both sides. Compared with the previous generation it adds width parametrisation, an explicit request FSM, byte strobes generated from DATA_W, misalignment/access-fault reporting, and full back-pressure from WB.

## Interface
- DATA_W, 64: datapath width, 32 or 64; ld/sd/lwu are illegal when 32.
- ADDR_W, 64: address width; must be ≤ DATA_W.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- ex_valid  in  1  EX presents an op.
- ls_ready  out  1  LSU can accept an op this cycle.
- alu_res  in  DATA_W  effective address, or result for non-memory ops.
- store_data  in  DATA_W  rs2 value for stores.
- ls_ctl  in  4  0000 none; loads 1001 lb, 1010 lh, 1011 lw, 1100 ld, 1101 lbu, 1110 lhu, 1111 lwu; stores 0001 sb, 0010 sh, 0100 sw, 0101 sd; other codes are illegal.
- ls_valid  out  1  result valid to WB.
- wb_ready  in  1  WB accepts result.
- ls_data_o  out  DATA_W  extended load data, alu_res passthrough, or 0 for stores.
- ls_exc  out  2  00 none, 01 misaligned, 10 access fault, 11 illegal ls_ctl.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_we  out  1  1 write, 0 read.
- mem_addr  out  ADDR_W  address aligned down to DATA_W/8 bytes.
- mem_wdata  out  DATA_W  store data shifted to byte lane.
- mem_wstrb  out  DATA_W/8  byte enables; 0 for reads.
- mem_rvalid  in  1  response (read data or write ack).
- mem_rdata  in  DATA_W  read data.
- mem_err  in  1  access fault, qualified by mem_rvalid.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- ls_ready = (state==IDLE) | (state==DONE & wb_ready). The op is accepted on ex_valid & ls_ready; alu_res, store_data and ls_ctl are registered at acceptance.
- Accepted op with ls_ctl==0000, misaligned, or illegal: go to DONE directly, with no memory request.
  - Non-memory op: data = alu_res, exc = 00.
  - Misaligned op: data = 0, exc = 01.
  - Illegal op: data = 0, exc = 11.
- Accepted legal, aligned memory op goes to REQ.
- Misaligned means the address is not a multiple of the access size (h: 2, w: 4, d: 8).
- REQ: mem_req_valid=1, with addr/we/wdata/wstrb held stable. On mem_req_ready go to WAIT. mem_req_valid never drops before the handshake.
- WAIT: on mem_rvalid capture mem_rdata (loads) and mem_err, then go to DONE. mem_rvalid outside WAIT is ignored.
- Load extraction:
  - Byte/half/word lane chosen by the low address bits.
  - lb/lh/lw sign-extend to DATA_W; lbu/lhu/lwu zero-extend.
  - ld returns the full word.
  - If mem_err, data = 0 and exc = 10.
- Store: the lane is replicated/shifted to the byte offset; wstrb has 1/2/4/8 contiguous bits at the offset. Store result data = 0.
- DONE: ls_valid=1 with data/exc held stable until wb_ready. On wb_ready, go to IDLE, or capture the next op if ex_valid (back-to-back, no bubble).
- Reset (rst==0) in any state: state=IDLE, all outputs 0 except ls_ready=1. A mid-flight transaction is abandoned and its late mem_rvalid is ignored.

## Timing
- Non-memory/trapped op: accepted in cycle N, ls_valid in N+1.
- Memory op: accepted in N, mem_req_valid in N+1. If ready in N+1 and rvalid in N+2, ls_valid is in N+3. Minimum load-use latency is 3 cycles.
- Each mem_req_ready stall cycle and each rvalid wait cycle adds one cycle.
- All outputs are registered or decoded from registered state; there are no combinational paths from mem_* inputs to ex-side outputs. ls_ready depends combinationally on wb_ready only.
- Throughput: 1 op per cycle for non-memory ops with wb_ready held at 1; 1 op per 3 cycles for zero-wait memory.

## Test plan
- DATA_W=64, lb at addr 0x...1003, mem_rdata=0x0000_0000_8000_0000 ready/rvalid immediate → mem_addr=...1000, wstrb=0, ls_data_o=0xFFFF_FFFF_FFFF_FF80 at N+3; lbu → 0x80.
- sh store_data=0xABCD at addr ...06 → mem_wdata[63:48]=0xABCD, wstrb=8'b1100_0000, mem_we=1; ls_valid after write ack, data=0.
- lw at addr ...02 → no mem_req_valid, ls_valid at N+1, ls_exc=01. ld with DATA_W=32 → ls_exc=11.
- mem_req_ready low 4 cycles, then rvalid with mem_err=1 → request held stable throughout, ls_exc=10, data=0.
- wb_ready low 3 cycles in DONE with ex_valid high → ls_data_o stable, ls_ready=0; on wb_ready the next op is accepted the same cycle.
- rst low while in WAIT, rvalid arrives next cycle → IDLE, ls_valid stays 0, no spurious result.
